// File: rtl/apb_mem_ap.sv
// APB memory access port: decodes debug-port AP requests into CSW/TAR/IDR
// register accesses and DRW/BDx transfers on an APB master interface.
module apb_mem_ap #(
  parameter logic [7:0]  AP_SEL = 8'h00,
  parameter logic [31:0] AP_IDR = 32'h0477_0002,
  parameter int          APB_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_upd,
  input  logic [7:0]        ap_sel,
  input  logic [5:0]        ap_addr,
  input  logic [31:0]       ap_wdata,
  input  logic              ap_rnw,
  input  logic              ap_abort,
  output logic              ap_busy,
  output logic [31:0]       ap_rdata,
  output logic              ap_slverr,
  output logic [2:0]        ap_ack,
  output logic              psel,
  output logic              penable,
  output logic [APB_AW-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [5:0] A_CSW = 6'h00;
  localparam logic [5:0] A_TAR = 6'h01;
  localparam logic [5:0] A_DRW = 6'h03;
  localparam logic [5:0] A_BD0 = 6'h04;
  localparam logic [5:0] A_BD1 = 6'h05;
  localparam logic [5:0] A_BD2 = 6'h06;
  localparam logic [5:0] A_BD3 = 6'h07;
  localparam logic [5:0] A_IDR = 6'h3F;

  // Byte lanes for a write of the given size at the given address offset.
  function automatic logic [3:0] strb_calc(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] strb;
    case (size)
      3'd0:    strb = 4'b0001 << lsb;
      3'd1:    strb = lsb[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          size_r, size_s;
  logic [1:0]          inc_r, inc_s;
  logic [31:0]         tar_r, tar_s;
  logic                drw_r, drw_s;
  logic [31:0]         rdata_s;
  logic                slverr_s;
  logic [APB_AW-1:0]   paddr_s;
  logic                pwrite_s;
  logic [31:0]         pwdata_s;
  logic [3:0]          pstrb_s;
  logic                busy_s;
  logic                psel_s;
  logic                penable_s;
  logic [2:0]          ack_s;
  logic [31:0]         addr32_s;
  logic [31:0]         csw_rd_s;
  logic [9:0]          tar_inc_s;

  // Transfer address: DRW uses TAR directly, BDn replaces TAR[3:0] with {n, 2'b00}.
  assign addr32_s  = (ap_addr == A_DRW) ? tar_r : {tar_r[31:4], ap_addr[1:0], 2'b00};
  assign csw_rd_s  = {24'h0, ap_busy, 1'b1, inc_r, 1'b0, size_r};
  // Increment wraps inside the 1 KB block; the upper TAR bits are kept.
  assign tar_inc_s = tar_r[9:0] + (10'd1 << size_r);

  // Next-state, register-file and APB output computation.
  always_comb begin
    state_s  = state_r;
    size_s   = size_r;
    inc_s    = inc_r;
    tar_s    = tar_r;
    drw_s    = drw_r;
    rdata_s  = ap_rdata;
    slverr_s = ap_slverr;
    paddr_s  = paddr;
    pwrite_s = pwrite;
    pwdata_s = pwdata;
    pstrb_s  = pstrb;

    if (ap_abort) begin
      slverr_s = 1'b0;
      state_s  = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ap_upd && (ap_sel != AP_SEL)) begin
            if (ap_rnw) begin
              rdata_s = 32'h0;
            end else begin
              rdata_s = ap_rdata;
            end
          end else if (ap_upd) begin
            case (ap_addr)
              A_CSW: begin
                if (ap_rnw) begin
                  rdata_s = csw_rd_s;
                end else begin
                  size_s = (ap_wdata[2:0] > 3'h2) ? 3'h2 : ap_wdata[2:0];
                  inc_s  = ap_wdata[5] ? 2'b00 : ap_wdata[5:4];
                end
              end
              A_TAR: begin
                if (ap_rnw) begin
                  rdata_s = tar_r;
                end else begin
                  tar_s = ap_wdata;
                end
              end
              A_DRW, A_BD0, A_BD1, A_BD2, A_BD3: begin
                state_s  = ST_SETUP;
                drw_s    = (ap_addr == A_DRW);
                paddr_s  = addr32_s[APB_AW-1:0];
                pwrite_s = ~ap_rnw;
                pwdata_s = ap_wdata;
                pstrb_s  = ap_rnw ? 4'b0000 : strb_calc(size_r, tar_r[1:0]);
              end
              A_IDR: begin
                if (ap_rnw) begin
                  rdata_s = AP_IDR;
                end else begin
                  rdata_s = ap_rdata;
                end
              end
              default: begin
                if (ap_rnw) begin
                  rdata_s = 32'h0;
                end else begin
                  rdata_s = ap_rdata;
                end
              end
            endcase
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_s = ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            state_s = ST_IDLE;
            if (!pwrite) begin
              rdata_s = prdata;
            end else begin
              rdata_s = ap_rdata;
            end
            if (pslverr) begin
              slverr_s = 1'b1;
            end else if (drw_r && (inc_r == 2'b01)) begin
              tar_s = {tar_r[31:10], tar_inc_s};
            end else begin
              tar_s = tar_r;
            end
          end else begin
            state_s = ST_ACCESS;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    busy_s    = (state_s != ST_IDLE);
    psel_s    = busy_s;
    penable_s = (state_s == ST_ACCESS);
    ack_s     = busy_s ? 3'h1 : 3'h2;
  end

  // State, register file and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      size_r    <= 3'h2;
      inc_r     <= 2'b00;
      tar_r     <= 32'h0;
      drw_r     <= 1'b0;
      ap_busy   <= 1'b0;
      ap_rdata  <= 32'h0;
      ap_slverr <= 1'b0;
      ap_ack    <= 3'h2;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= 32'h0;
      pstrb     <= 4'h0;
    end else begin
      state_r   <= state_s;
      size_r    <= size_s;
      inc_r     <= inc_s;
      tar_r     <= tar_s;
      drw_r     <= drw_s;
      ap_busy   <= busy_s;
      ap_rdata  <= rdata_s;
      ap_slverr <= slverr_s;
      ap_ack    <= ack_s;
      psel      <= psel_s;
      penable   <= penable_s;
      paddr     <= paddr_s;
      pwrite    <= pwrite_s;
      pwdata    <= pwdata_s;
      pstrb     <= pstrb_s;
    end
  end

endmodule

// File: doc/apb_mem_ap.md
Name: apb_mem_ap

Overview:
- APB memory access port (MEM-AP) on the system clock. It consumes the AP request bus driven by the JTAG debug port: `ap_upd`/`ap_sel`/`ap_addr`/`ap_wdata`/`ap_rnw`.
- It returns `ap_busy`/`ap_rdata`/`ap_slverr`/`ap_ack` to the debug port.
- It turns DRW/BDx accesses into APB master transfers into the SoC debug/memory fabric. Request inputs arrive already synchronised into the `clk` domain.

Parameters:
- AP_SEL, 8'h00, APSEL value this AP responds to.
- AP_IDR, 32'h0477_0002, value returned for IDR reads.
- APB_AW, 32, APB address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- ap_upd  input  1  single-cycle request strobe from the debug port.
- ap_sel  input  8  selected AP number.
- ap_addr  input  6  AP register word address [7:2].
- ap_wdata  input  32  write data.
- ap_rnw  input  1  1 = read, 0 = write.
- ap_abort  input  1  pulse; clears sticky error and aborts the in-flight APB transfer.
- ap_busy  output  1  request in progress.
- ap_rdata  output  32  result of the last completed read.
- ap_slverr  output  1  sticky APB error.
- ap_ack  output  3  3'h2 OK/FAULT when idle, 3'h1 WAIT when busy.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- paddr  output  APB_AW  APB address.
- pwrite  output  1  APB write.
- pwdata  output  32  APB write data.
- pstrb  output  4  APB byte strobes.
- prdata  input  32  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.

Behaviour:
- Reset (rst=1, async) sets all outputs to 0 except `ap_ack`=3'h2. CSW size=3'h2 (word), AddrInc=2'b00, TAR=0. FSM goes to IDLE.
- Register map (`ap_addr`):
  - 0x00 CSW: [5:4] AddrInc, [2:0] Size. Read value is {24'h0, TrInProg[7], DeviceEn[6]=1, AddrInc, 1'b0, Size}.
  - 0x01 TAR.
  - 0x03 DRW.
  - 0x04-0x07 BD0-BD3.
  - 0x3F IDR (read-only).
  - Other addresses: reads return 0, writes are ignored.
- Size writes above 3'h2 store 3'h2. AddrInc values 2'b1x store 2'b00.
- Request with `ap_sel`≠AP_SEL: 1-cycle no-op; reads set `ap_rdata`=0.
- CSW/TAR/IDR/unmapped accesses take 1 cycle.
  - Register updated, or `ap_rdata` loaded, on the clk edge after `ap_upd`.
  - `ap_busy` is never asserted for these.
- DRW/BDx accesses use FSM IDLE -> SETUP -> ACCESS -> IDLE.
  - The `ap_upd` edge enters SETUP. `ap_busy`=1 from that edge until the edge returning to IDLE.
  - SETUP: `psel`=1, `penable`=0; paddr/pwrite/pwdata/pstrb are valid and held constant through ACCESS.
  - ACCESS: `psel`=`penable`=1. Stays in ACCESS while `pready`=0. When `pready`=1, returns to IDLE.
  - On return to IDLE: `psel`/`penable`=0 and `ap_busy`=0. For reads, `ap_rdata`←`prdata`.
  - Minimum latency is 2 cycles from `ap_upd` to `ap_busy` fall.
- Address formation:
  - DRW: `paddr`=TAR.
  - BDn: `paddr`={TAR[31:4], n, 2'b00}.
- Byte strobes:
  - Byte size: pstrb=4'b0001<<TAR[1:0].
  - Halfword size: pstrb = TAR[1] ? 4'b1100 : 4'b0011.
  - Word size: pstrb=4'b1111.
  - Reads also drive pstrb=0.
  - `pwdata`=`ap_wdata` unshifted.
- Auto-increment:
  - Applies after a DRW completion with `pslverr`=0 and AddrInc=01. Never applies to BDx.
  - TAR[9:0] += (1<<Size) and wraps within the 1 KB block; TAR[31:10] is unchanged.
- Errors:
  - `pslverr`=1 at completion sets `ap_slverr`, which stays sticky.
  - On an errored read, `ap_rdata` is still loaded and TAR is not incremented.
- `ap_abort` takes priority over everything:
  - Clears `ap_slverr`.
  - If in SETUP/ACCESS, forces IDLE next edge with `psel`/`penable`=0. No `ap_rdata` update, no TAR increment.
- `ap_upd` while `ap_busy`=1 is ignored; no state change.
- `ap_upd` together with `pready` completion on the same edge: the completion is processed and the new strobe is ignored.
- `ap_ack` = `ap_busy` ? 3'h1 : 3'h2. TrInProg = `ap_busy`.

Test Plan:
1. Write TAR=0x8000_0000, CSW=0x12 (word, AddrInc=01), DRW=0xCAFE_F00D with `pready` tied 1 -> one APB write: paddr 0x8000_0000, pstrb 4'hF, pwdata 0xCAFE_F00D; `ap_busy` high exactly 2 cycles; TAR reads 0x8000_0004.
2. TAR=0x1000_03FE, CSW Size=1 AddrInc=01, DRW read with `pready` low for 3 ACCESS cycles and `prdata`=0x1234_5678 -> pstrb 4'h0 on read, paddr 0x1000_03FE; `ap_busy` high 5 cycles; `ap_ack`=3'h1 meanwhile; `ap_rdata`=0x1234_5678; TAR wraps to 0x1000_0000.
3. BD2 write 0xA5 with TAR=0x2000_0013, Size=0 -> paddr 0x2000_0018, pstrb 4'b1000; TAR unchanged.
4. DRW write with `pslverr`=1 -> `ap_slverr`=1, TAR not incremented; `ap_abort` pulse -> `ap_slverr`=0.
5. `ap_abort` during ACCESS with `pready`=0 -> next edge `psel`=`penable`=`ap_busy`=0, `ap_rdata` unchanged; a second `ap_upd` during busy produces no extra APB transfer.
6. IDR read with `ap_sel`=AP_SEL -> `ap_rdata`=0x0477_0002; same read with `ap_sel`=AP_SEL+1 -> `ap_rdata`=0, no APB activity; assert rst mid-ACCESS -> all outputs 0 and `ap_ack`=3'h2 immediately.
